// File: rtl/map_ram_loader.sv
// map_ram_loader: 16x16 2-bit map store fed by a byte stream.
// Decodes full-map loads and single-cell writes; combinational read port.
module map_ram_loader #(
  parameter int          COLS     = 16,
  parameter int          ROWS     = 16,
  parameter int          BITS     = 2,
  parameter logic [7:0]  HDR_LOAD = 8'hA5,
  parameter logic [7:0]  HDR_CELL = 8'h5A
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            abort,
  input  logic [3:0]      row,
  input  logic [3:0]      col,
  output logic [BITS-1:0] val,
  output logic            busy,
  output logic            load_done,
  output logic            bad_header
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CELL_ADDR,
    CELL_VAL
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      n_q, n_d;
  logic [3:0]      trow_q, trow_d;
  logic [3:0]      tcol_q, tcol_d;
  logic [BITS-1:0] map_q [ROWS*COLS];
  logic [BITS-1:0] map_d [ROWS*COLS];
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            load_done_q, load_done_d;
  logic            bad_header_q, bad_header_d;
  logic            fire;

  function automatic logic [BITS-1:0] border(input logic [7:0] idx);
    logic edge_cell;
    edge_cell = (idx[7:4] == 4'd0) || (idx[7:4] == 4'd15) ||
                (idx[3:0] == 4'd0) || (idx[3:0] == 4'd15);
    return edge_cell ? 2'b11 : 2'b00;
  endfunction

  assign fire       = in_valid && in_ready_q;
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign bad_header = bad_header_q;
  assign val        = map_q[{row, col}];

  // Command decode and next-state/next-map computation
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    trow_d       = trow_q;
    tcol_d       = tcol_q;
    map_d        = map_q;
    load_done_d  = 1'b0;
    bad_header_d = bad_header_q;
    in_ready_d   = 1'b1;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      n_d     = 6'd0;
    end else if (fire) begin
      unique case (state_q)
        IDLE: begin
          if (in_data == HDR_LOAD) begin
            state_d      = LOAD;
            n_d          = 6'd0;
            bad_header_d = 1'b0;
          end else if (in_data == HDR_CELL) begin
            state_d      = CELL_ADDR;
            bad_header_d = 1'b0;
          end else begin
            bad_header_d = 1'b1;
          end
        end
        LOAD: begin
          for (int k = 0; k < 4; k++) begin
            map_d[{n_q, 2'(k)}] = in_data[2*k +: 2];
          end
          if (n_q == 6'd63) begin
            state_d     = IDLE;
            n_d         = 6'd0;
            load_done_d = 1'b1;
          end else begin
            n_d = n_q + 6'd1;
          end
        end
        CELL_ADDR: begin
          trow_d  = in_data[7:4];
          tcol_d  = in_data[3:0];
          state_d = CELL_VAL;
        end
        CELL_VAL: begin
          map_d[{trow_q, tcol_q}] = in_data[1:0];
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State, map and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      n_q          <= 6'd0;
      trow_q       <= 4'd0;
      tcol_q       <= 4'd0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      bad_header_q <= 1'b0;
      for (int i = 0; i < ROWS*COLS; i++) begin
        map_q[i] <= border(8'(i));
      end
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      trow_q       <= trow_d;
      tcol_q       <= tcol_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      bad_header_q <= bad_header_d;
      for (int i = 0; i < ROWS*COLS; i++) begin
        map_q[i] <= map_d[i];
      end
    end
  end

endmodule

// File: tb/tb_map_ram_loader.sv
// tb_map_ram_loader: directed plus random stimulus against a
// cell-array reference model of the map loader.
module tb_map_ram_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic [3:0] row;
  logic [3:0] col;
  logic [1:0] val;
  logic       busy;
  logic       load_done;
  logic       bad_header;

  int errors = 0;
  int checks = 0;
  int exp_map [256];

  map_ram_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .row        (row),
    .col        (col),
    .val        (val),
    .busy       (busy),
    .load_done  (load_done),
    .bad_header (bad_header)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        exp_map[r*16+c] = (r == 0 || r == 15 || c == 0 || c == 15) ? 3 : 0;
  endfunction

  function automatic void model_load(input int n, input int d);
    for (int k = 0; k < 4; k++)
      exp_map[(n / 4) * 16 + (n % 4) * 4 + k] = (d >> (2 * k)) & 3;
  endfunction

  task automatic check_map(input string tag);
    int nbad = 0;
    int fi = 0;
    int fo = 0;
    for (int i = 0; i < 256; i++) begin
      row = 4'(i / 16);
      col = 4'(i % 16);
      #1;
      if (val !== 2'(exp_map[i])) begin
        if (nbad == 0) begin
          fi = i;
          fo = int'(val);
        end
        nbad++;
      end
    end
    checks++;
    assert (nbad === 0) else begin
      errors++;
      $error("FAIL %s: %0d bad cells, first idx %0d observed=%0d expected=%0d",
             tag, nbad, fi, fo, exp_map[fi]);
    end
  endtask

  task automatic peek(input string tag, input int r, input int c,
                      input int e);
    row = 4'(r);
    col = 4'(c);
    #1;
    chk(tag, 32'(val), 32'(e));
  endtask

  task automatic send(input logic [7:0] b, input logic ab);
    in_data  = b;
    abort    = ab;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // full load: rnd selects random data, stall inserts a gap before each byte
  task automatic do_load(input bit rnd, input bit stall, input string tag);
    int  edges = 0;
    int  early = 0;
    logic [7:0] d;
    logic [5:0] nn;
    send(8'hA5, 1'b0);
    chk({tag, "_busy_hdr"}, 32'(busy), 32'd1);
    chk({tag, "_bad_hdr"}, 32'(bad_header), 32'd0);
    for (int n = 0; n < 64; n++) begin
      if (stall) begin
        idle();
        edges++;
        if (load_done !== 1'b0) early++;
      end
      nn = 6'(n);
      d  = rnd ? 8'($urandom) : {4{nn[1:0]}};
      send(d, 1'b0);
      edges++;
      model_load(n, int'(d));
      if (n < 63 && load_done !== 1'b0) early++;
    end
    chk({tag, "_done_pulse"}, 32'(load_done), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_no_early_done"}, 32'(early), 32'd0);
    chk({tag, "_edges"}, 32'(edges), stall ? 32'd128 : 32'd64);
  endtask

  task automatic do_cell(input int r, input int c, input logic [7:0] vb,
                         input string tag);
    send(8'h5A, 1'b0);
    chk({tag, "_busy1"}, 32'(busy), 32'd1);
    send({4'(r), 4'(c)}, 1'b0);
    chk({tag, "_busy2"}, 32'(busy), 32'd1);
    send(vb, 1'b0);
    chk({tag, "_busy3"}, 32'(busy), 32'd0);
    exp_map[r*16+c] = int'(vb[1:0]);
    peek({tag, "_val"}, r, c, int'(vb[1:0]));
  endtask

  initial begin
    int kind;
    int k;
    logic [7:0] d;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    abort    = 1'b0;
    row      = 4'd0;
    col      = 4'd0;

    // reset
    idle();
    chk("rst_ready", 32'(in_ready), 32'd0);
    idle();
    chk("rst_ready2", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_bad", 32'(bad_header), 32'd0);
    reset_n = 1'b1;
    idle();
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    model_reset();
    peek("rst_0_0", 0, 0, 3);
    peek("rst_0_7", 0, 7, 3);
    peek("rst_15_15", 15, 15, 3);
    peek("rst_5_5", 5, 5, 0);
    peek("rst_14_1", 14, 1, 0);
    check_map("rst_map");

    // full load with cycling pattern
    do_load(1'b0, 1'b0, "load");
    idle();
    chk("load_done_clear", 32'(load_done), 32'd0);
    peek("load_3_9", 3, 9, 2);
    check_map("load_map");

    // single-cell write
    do_cell(7, 12, 8'hFE, "cell");
    peek("cell_7_12", 7, 12, 2);
    check_map("cell_map");

    // bad header then valid header, then abort mid-load
    send(8'h33, 1'b0);
    chk("bad_set", 32'(bad_header), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    send(8'hA5, 1'b0);
    chk("bad_clear", 32'(bad_header), 32'd0);
    for (int n = 0; n < 10; n++) begin
      send(8'hFF, 1'b0);
      model_load(n, 8'hFF);
    end
    send(8'hFF, 1'b1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(load_done), 32'd0);
    chk("abort_bad", 32'(bad_header), 32'd0);
    peek("abort_2_7", 2, 7, 3);
    peek("abort_2_8", 2, 8, 2);
    check_map("abort_map");
    do_cell(2, 3, 8'h01, "after_abort");

    // abort while idle must not block a header
    send(8'h5A, 1'b1);
    chk("idle_abort_busy", 32'(busy), 32'd1);
    send(8'h9A, 1'b0);
    send(8'hFD, 1'b0);
    exp_map[9*16+10] = 1;
    check_map("idle_abort_map");

    // stalled full load
    model_reset();
    do_load(1'b0, 1'b1, "stall");
    check_map("stall_map");

    // random commands, back to back where they chain
    for (int it = 0; it < 8; it++) begin
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        do_load(1'b1, 1'b0, "rload");
        do_cell(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                8'($urandom), "rchain");
      end else if (kind == 1) begin
        do_cell(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                8'($urandom), "rcell");
      end else if (kind == 2) begin
        k = int'($urandom_range(1, 60));
        send(8'hA5, 1'b0);
        for (int n = 0; n < k; n++) begin
          d = 8'($urandom);
          send(d, 1'b0);
          model_load(n, int'(d));
        end
        abort = 1'b1;
        idle();
        abort = 1'b0;
        chk("rabort_busy", 32'(busy), 32'd0);
        chk("rabort_done", 32'(load_done), 32'd0);
      end else begin
        d = 8'($urandom);
        if (d == 8'hA5 || d == 8'h5A) d = 8'h00;
        send(d, 1'b0);
        chk("rbad", 32'(bad_header), 32'd1);
        do_cell(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                8'($urandom), "rbad_cell");
        chk("rbad_clr", 32'(bad_header), 32'd0);
      end
      check_map("rand_map");
    end

    // reset in the middle of a load restores the border map
    send(8'hA5, 1'b0);
    send(8'h12, 1'b0);
    reset_n = 1'b0;
    idle();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    idle();
    model_reset();
    check_map("mid_rst_map");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
